// File: rtl/atm_pkg.sv
// Shared ATM definitions: keypad entry state, entry word geometry and the
// reserved "no entry" word value that the FSM also checks against.
package atm_pkg;

  localparam int ENTRY_DIGITS = 3;
  localparam int ENTRY_W      = 12;

  // Zero is reserved by the FSM to mean "nothing entered", so it can never be committed.
  localparam logic [ENTRY_W-1:0] NO_ENTRY = 12'h000;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } entry_state_e;

endpackage

// File: rtl/atm_debounce.sv
// Two-flop synchroniser plus stability-counter debouncer for one button level.
// It emits a single-cycle pulse when the accepted level rises.
module atm_debounce #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic [CNT_W-1:0] run_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      run_cnt <= '0;
      press   <= 1'b0;
    end else begin
      // sync_p0 -> sync_p1 -> stability check
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      if (sync_p1 != stable) begin
        // The last differing sample completes the run, so accept it now.
        if (run_cnt == RUN_LAST) begin
          stable  <= sync_p1;
          run_cnt <= '0;
          press   <= sync_p1;
        end else begin
          run_cnt <= run_cnt + CNT_W'(1);
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad front end for the ATM FSM: debounces keys/ENTER/CLEAR, shifts three
// hex digits into an entry word and commits it with a one-cycle load strobe.
module atm_keypad_entry
  import atm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int TIMEOUT_CYCLES  = 10000,
  parameter int CNT_W           = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_press,
  input  logic [3:0]         key_code,
  input  logic               btn_enter,
  input  logic               btn_clear,
  output logic [ENTRY_W-1:0] entry_word,
  output logic               load,
  output logic [1:0]         digit_count,
  output logic               entry_err,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [3:0]         key_code_p0, key_code_p1;
  logic               key_pulse, enter_pulse, clear_pulse;

  entry_state_e       state_q, state_n;
  logic [ENTRY_W-1:0] shift_q, shift_n;
  logic [1:0]         cnt_q, cnt_n;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_n;
  logic [ENTRY_W-1:0] word_q, word_n;
  logic               load_q, load_n;
  logic               err_q, err_n;
  logic               tmo_q, tmo_n;

  atm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_key (
    .clk(clk), .rst(rst), .raw(key_press), .press(key_pulse)
  );
  atm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_enter (
    .clk(clk), .rst(rst), .raw(btn_enter), .press(enter_pulse)
  );
  atm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clear (
    .clk(clk), .rst(rst), .raw(btn_clear), .press(clear_pulse)
  );

  // key_code_p0 -> key_code_p1, consumed when the key press pulse fires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code_p0 <= '0;
      key_code_p1 <= '0;
    end else begin
      key_code_p0 <= key_code;
      key_code_p1 <= key_code_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      shift_q   <= '0;
      cnt_q     <= '0;
      tmo_cnt_q <= '0;
      word_q    <= '0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      shift_q   <= shift_n;
      cnt_q     <= cnt_n;
      tmo_cnt_q <= tmo_cnt_n;
      word_q    <= word_n;
      load_q    <= load_n;
      err_q     <= err_n;
      tmo_q     <= tmo_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    shift_n   = shift_q;
    cnt_n     = cnt_q;
    tmo_cnt_n = tmo_cnt_q;
    word_n    = word_q;
    load_n    = 1'b0;
    err_n     = 1'b0;
    tmo_n     = 1'b0;

    // Priority CLEAR > ENTER > digit; lower-priority presses in the same cycle are dropped.
    if (clear_pulse) begin
      shift_n = '0;
      cnt_n   = '0;
      state_n = EMPTY;
    end else if (enter_pulse) begin
      if (state_q == FULL && shift_q != NO_ENTRY) begin
        word_n = shift_q;
        load_n = 1'b1;
      end else begin
        err_n = 1'b1;
      end
      shift_n = '0;
      cnt_n   = '0;
      state_n = EMPTY;
    end else if (key_pulse) begin
      if (state_q == FULL) begin
        err_n = 1'b1;
      end else begin
        shift_n = {shift_q[ENTRY_W-5:0], key_code_p1};
        cnt_n   = cnt_q + 2'd1;
        state_n = (cnt_q == 2'(ENTRY_DIGITS - 1)) ? FULL : PARTIAL;
      end
    end

    // Any press restarts the idle window, so a press on the expiry cycle wins.
    if (clear_pulse || enter_pulse || key_pulse || state_q == EMPTY) begin
      tmo_cnt_n = '0;
    end else if (tmo_cnt_q >= TMO_LAST) begin
      shift_n   = '0;
      cnt_n     = '0;
      state_n   = EMPTY;
      tmo_n     = 1'b1;
      tmo_cnt_n = '0;
    end else begin
      tmo_cnt_n = tmo_cnt_q + CNT_W'(1);
    end
  end

  assign entry_word  = word_q;
  assign load        = load_q;
  assign digit_count = cnt_q;
  assign entry_err   = err_q;
  assign timeout     = tmo_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Bench for atm_keypad_entry: directed table, multi-cycle corner sequences and
// random stimulus checked every cycle against a behavioural model.
module tb_atm_keypad_entry;

  localparam int DEB  = 4;
  localparam int TMO  = 50;
  localparam int CW   = 14;
  localparam int HMAX = 16384;

  logic        clk;
  logic        rst;
  logic        key_press;
  logic [3:0]  key_code;
  logic        btn_enter;
  logic        btn_clear;
  logic [11:0] entry_word;
  logic        load;
  logic [1:0]  digit_count;
  logic        entry_err;
  logic        timeout;

  atm_keypad_entry #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .key_press(key_press), .key_code(key_code),
    .btn_enter(btn_enter), .btn_clear(btn_clear), .entry_word(entry_word),
    .load(load), .digit_count(digit_count), .entry_err(entry_err), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Raw input history, one entry per rising clock edge.
  bit       h_in[3][HMAX];
  bit [3:0] h_code[HMAX];
  int       n = 0;
  int       rst_edge = 0;

  // Behavioural model state.
  bit          stable[3];
  bit          pend[3];
  int          q[$];
  logic [11:0] m_word;
  bit          m_load, m_err, m_tmo;
  int          idle;

  // Pulse observation for directed checks.
  int ld_seen, err_seen, to_seen;

  function automatic bit samp(int b, int i);
    if (i < 0 || i < rst_edge) return 1'b0;
    return h_in[b][i];
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      stable[b] = 1'b0;
      pend[b]   = 1'b0;
    end
    q.delete();
    m_word = '0;
    m_load = 0; m_err = 0; m_tmo = 0;
    idle = 0;
  endtask

  task automatic model_step();
    bit all_diff;
    int v;
    bit [3:0] c;
    if (rst) begin
      model_reset();
      rst_edge = n + 1;
      return;
    end
    m_load = 0; m_err = 0; m_tmo = 0;
    if (pend[2]) begin
      q.delete(); idle = 0;
    end else if (pend[1]) begin
      if (q.size() == 3) v = (q[0] << 8) | (q[1] << 4) | q[2];
      else v = 0;
      if (q.size() == 3 && v != 0) begin
        m_word = 12'(v); m_load = 1;
      end else begin
        m_err = 1;
      end
      q.delete(); idle = 0;
    end else if (pend[0]) begin
      c = (n - 2 < 0 || n - 2 < rst_edge) ? 4'h0 : h_code[n-2];
      if (q.size() == 3) m_err = 1;
      else q.push_back(int'(c));
      idle = 0;
    end else if (q.size() == 0) begin
      idle = 0;
    end else begin
      idle++;
      if (idle >= TMO) begin
        q.delete(); m_tmo = 1; idle = 0;
      end
    end
    // A button level flips once the last DEB synchronised samples all disagree with it.
    for (int b = 0; b < 3; b++) begin
      all_diff = 1;
      for (int k = 2; k <= DEB + 1; k++)
        if (samp(b, n - k) == stable[b]) all_diff = 0;
      pend[b] = 0;
      if (all_diff) begin
        stable[b] = ~stable[b];
        pend[b]   = stable[b];
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [16:0] got, exp;
    got = {entry_word, load, digit_count, entry_err, timeout};
    exp = {m_word, m_load, 2'(q.size()), m_err, m_tmo};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL model_%s cyc=%0d got word=%h ld=%b cnt=%0d err=%b to=%b, expected word=%h ld=%b cnt=%0d err=%b to=%b",
               tag, n, got[16:5], got[4], got[3:2], got[1], got[0],
               exp[16:5], exp[4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    h_in[0][n] = key_press;
    h_in[1][n] = btn_enter;
    h_in[2][n] = btn_clear;
    h_code[n]  = key_code;
    model_step();
    n++;
    @(negedge clk);
    if (load === 1'b1) ld_seen++;
    if (entry_err === 1'b1) err_seen++;
    if (timeout === 1'b1) to_seen++;
    check_model("cycle");
  endtask

  // kind: 0 digit, 1 ENTER, 2 CLEAR. Returns tick index of the first load pulse.
  task automatic press(input int kind, input logic [3:0] code, output int first_load);
    first_load = 0;
    if (kind == 0) begin
      key_code = code; key_press = 1'b1;
    end else if (kind == 1) begin
      btn_enter = 1'b1;
    end else begin
      btn_clear = 1'b1;
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (load === 1'b1 && first_load == 0) first_load = i;
    end
    key_press = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0;
    repeat (10) tick();
  endtask

  typedef struct {
    int          kind;
    logic [3:0]  code;
    int          exp_cnt;
    int          exp_load;
    int          exp_err;
    logic [11:0] exp_word;
  } vec_t;

  vec_t tbl[18];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int fl, t, cnt_ok;
    rst = 1'b1;
    key_press = 1'b0; key_code = 4'h0; btn_enter = 1'b0; btn_clear = 1'b0;
    model_reset();

    tbl[0]  = '{0, 4'hA, 1, 0, 0, 12'h000};
    tbl[1]  = '{0, 4'h1, 2, 0, 0, 12'h000};
    tbl[2]  = '{0, 4'h1, 3, 0, 0, 12'h000};
    tbl[3]  = '{1, 4'h0, 0, 1, 0, 12'hA11};
    tbl[4]  = '{0, 4'hB, 1, 0, 0, 12'hA11};
    tbl[5]  = '{0, 4'h2, 2, 0, 0, 12'hA11};
    tbl[6]  = '{1, 4'h0, 0, 0, 1, 12'hA11};
    tbl[7]  = '{0, 4'h0, 1, 0, 0, 12'hA11};
    tbl[8]  = '{0, 4'h0, 2, 0, 0, 12'hA11};
    tbl[9]  = '{0, 4'h0, 3, 0, 0, 12'hA11};
    tbl[10] = '{1, 4'h0, 0, 0, 1, 12'hA11};
    tbl[11] = '{0, 4'hC, 1, 0, 0, 12'hA11};
    tbl[12] = '{0, 4'h3, 2, 0, 0, 12'hA11};
    tbl[13] = '{0, 4'h3, 3, 0, 0, 12'hA11};
    tbl[14] = '{0, 4'h5, 3, 0, 1, 12'hA11};
    tbl[15] = '{1, 4'h0, 0, 1, 0, 12'hC33};
    tbl[16] = '{0, 4'h7, 1, 0, 0, 12'hC33};
    tbl[17] = '{2, 4'h0, 0, 0, 0, 12'hC33};

    // Reset state
    repeat (3) tick();
    chk("reset_word", int'(entry_word), 0);
    chk("reset_flags", int'({load, digit_count, entry_err, timeout}), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Directed table
    for (int i = 0; i < 18; i++) begin
      ld_seen = 0; err_seen = 0;
      press(tbl[i].kind, tbl[i].code, fl);
      chk($sformatf("vec%0d_count", i), int'(digit_count), tbl[i].exp_cnt);
      chk($sformatf("vec%0d_loads", i), ld_seen, tbl[i].exp_load);
      chk($sformatf("vec%0d_errs", i), err_seen, tbl[i].exp_err);
      chk($sformatf("vec%0d_word", i), int'(entry_word), int'(tbl[i].exp_word));
      if (tbl[i].exp_load == 1) chk($sformatf("vec%0d_load_latency", i), fl, 2 + DEB + 1);
    end

    // Bouncing key: 3 high, 1 low, then held
    err_seen = 0; t = 0; cnt_ok = 0;
    key_code = 4'h6; key_press = 1'b1;
    for (int i = 1; i <= 3; i++) begin tick(); if (digit_count != 0 && t == 0) t = i; end
    key_press = 1'b0;
    tick(); if (digit_count != 0 && t == 0) t = 4;
    key_press = 1'b1;
    for (int i = 5; i <= 25; i++) begin tick(); if (digit_count != 0 && t == 0) t = i; end
    key_press = 1'b0;
    repeat (10) tick();
    chk("bounce_accept_cycle", t, 11);
    chk("bounce_single_digit", int'(digit_count), 1);
    chk("bounce_no_err", err_seen, 0);
    press(2, 4'h0, fl);

    // Idle timeout with one digit
    ld_seen = 0; to_seen = 0;
    press(0, 4'hD, fl);
    for (int i = 0; i < 80 && to_seen == 0; i++) tick();
    chk("timeout_seen", to_seen, 1);
    chk("timeout_count", int'(digit_count), 0);
    chk("timeout_no_load", ld_seen, 0);
    chk("timeout_word_kept", int'(entry_word), 12'hC33);

    // CLEAR and ENTER together on a partial buffer
    press(0, 4'h1, fl);
    press(0, 4'h2, fl);
    ld_seen = 0; err_seen = 0;
    btn_clear = 1'b1; btn_enter = 1'b1;
    repeat (12) tick();
    btn_clear = 1'b0; btn_enter = 1'b0;
    repeat (10) tick();
    chk("clr_ent_count", int'(digit_count), 0);
    chk("clr_ent_no_err", err_seen, 0);
    chk("clr_ent_no_load", ld_seen, 0);

    // Digit landing exactly on the expiry cycle suppresses the timeout
    key_code = 4'h1; key_press = 1'b1; t = 0;
    for (int i = 0; i < 20 && digit_count == 0; i++) tick();
    chk("expiry_first_digit", int'(digit_count), 1);
    key_press = 1'b0;
    repeat (43) tick();
    to_seen = 0;
    key_code = 4'h2; key_press = 1'b1;
    repeat (7) tick();
    chk("expiry_press_wins_count", int'(digit_count), 2);
    chk("expiry_press_wins_no_timeout", to_seen, 0);
    key_press = 1'b0;
    repeat (10) tick();
    press(2, 4'h0, fl);

    // Asynchronous reset mid-entry, then a normal commit
    press(0, 4'h4, fl);
    press(0, 4'h5, fl);
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_word", int'(entry_word), 0);
    chk("async_rst_flags", int'({load, digit_count, entry_err, timeout}), 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    press(0, 4'h5, fl);
    press(0, 4'hE, fl);
    press(0, 4'h7, fl);
    ld_seen = 0;
    press(1, 4'h0, fl);
    chk("post_rst_word", int'(entry_word), 12'h5E7);
    chk("post_rst_load", ld_seen, 1);

    // Random stimulus against the model
    for (int seg = 0; seg < 15; seg++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      for (int c = 0; c < 200; c++) begin
        if (mode == 0) begin
          key_press = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0;
        end else begin
          if (key_press == 1'b0 && $urandom_range(0, 5) == 0) key_code = 4'($urandom);
          if ($urandom_range(0, 5) == 0) key_press = ~key_press;
          if ($urandom_range(0, 9) == 0) btn_enter = ~btn_enter;
          if ($urandom_range(0, (mode == 1) ? 79 : 29) == 0) btn_clear = ~btn_clear;
        end
        if ($urandom_range(0, 1499) == 0) begin
          rst = 1'b1;
          #1;
          model_reset();
          check_model("async_rst");
          tick();
          rst = 1'b0;
        end
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
